// File: rtl/execute_pipe_if.sv
// Execute-to-memory stage bus: upstream valid/ready with payload, downstream valid/ready with head entry.
// The stage itself connects through the slave modport; the producer/consumer side uses master.
interface execute_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic            load_in;
    logic            store_in;
    logic            next_sel_in;
    logic [1:0]      mem_to_reg_in;
    logic [XLEN-1:0] alu_result_in;
    logic [XLEN-1:0] store_data_in;
    logic [XLEN-1:0] pre_address_in;
    logic [XLEN-1:0] instruction_in;

    logic            out_valid;
    logic            out_ready;
    logic            load;
    logic            store;
    logic            next_sel;
    logic [1:0]      mem_to_reg;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] pre_address;
    logic [XLEN-1:0] instruction;

    modport master (
        output in_valid, load_in, store_in, next_sel_in, mem_to_reg_in,
               alu_result_in, store_data_in, pre_address_in, instruction_in, out_ready,
        input  in_ready, out_valid, load, store, next_sel, mem_to_reg,
               alu_result, store_data, pre_address, instruction
    );

    modport slave (
        input  in_valid, load_in, store_in, next_sel_in, mem_to_reg_in,
               alu_result_in, store_data_in, pre_address_in, instruction_in, out_ready,
        output in_ready, out_valid, load, store, next_sel, mem_to_reg,
               alu_result, store_data, pre_address, instruction
    );
endinterface

// File: rtl/execute_pipe.sv
// EX/MEM register with 2-entry skid buffer; accept-to-output latency 1 cycle, 1 instr/cycle.
// in_ready/out_valid are pure flops, so out_ready never reaches in_ready combinationally.
module execute_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    execute_pipe_if.slave    bus,
    output logic [CNT_W-1:0] o_stall_cycles
);

    typedef struct packed {
        logic            load;
        logic            store;
        logic            next_sel;
        logic [1:0]      mem_to_reg;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] store_data;
        logic [XLEN-1:0] pre_address;
        logic [XLEN-1:0] instruction;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_out_valid;
    logic             r_in_ready;
    entry_t           r_main;
    entry_t           r_skid;
    entry_t           w_in;
    logic             w_accept;
    logic             w_drain;
    logic             w_main_from_in;
    logic             w_main_from_skid;
    logic             w_skid_from_in;
    logic [CNT_W-1:0] r_stall;

    assign w_in.load        = bus.load_in;
    assign w_in.store       = bus.store_in;
    assign w_in.next_sel    = bus.next_sel_in;
    assign w_in.mem_to_reg  = bus.mem_to_reg_in;
    assign w_in.alu_result  = bus.alu_result_in;
    assign w_in.store_data  = bus.store_data_in;
    assign w_in.pre_address = bus.pre_address_in;
    assign w_in.instruction = bus.instruction_in;

    assign w_accept = bus.in_valid & r_in_ready;
    assign w_drain  = r_out_valid & bus.out_ready;

    // Handshake flags are registered from the next state rather than decoded from r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_next_state;
            r_out_valid <= (w_next_state != S_EMPTY);
            r_in_ready  <= (w_next_state != S_FULL);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_next_state = S_ONE;
            S_ONE: begin
                if (w_accept && !w_drain)      w_next_state = S_FULL;
                else if (!w_accept && w_drain) w_next_state = S_EMPTY;
            end
            S_FULL:  if (w_drain) w_next_state = S_ONE;
            default: w_next_state = S_EMPTY;
        endcase
        if (i_flush) w_next_state = S_EMPTY;
    end

    always_comb begin
        w_main_from_in   = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_from_in   = 1'b0;
        if (!i_flush) begin
            case (r_state)
                S_EMPTY: w_main_from_in = w_accept;
                S_ONE: begin
                    w_main_from_in = w_accept & w_drain;
                    w_skid_from_in = w_accept & ~w_drain;
                end
                S_FULL:  w_main_from_skid = w_drain;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= '0;
        end else if (w_main_from_in) begin
            r_main <= w_in;
        end else if (w_main_from_skid) begin
            r_main <= r_skid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid <= '0;
        end else if (w_skid_from_in) begin
            r_skid <= w_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
        end else if (r_out_valid && !bus.out_ready && (r_stall != '1)) begin
            r_stall <= r_stall + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    // Memory side effects are suppressed on bubbles; the rest of the payload just holds.
    assign bus.load        = r_main.load & r_out_valid;
    assign bus.store       = r_main.store & r_out_valid;
    assign bus.next_sel    = r_main.next_sel;
    assign bus.mem_to_reg  = r_main.mem_to_reg;
    assign bus.alu_result  = r_main.alu_result;
    assign bus.store_data  = r_main.store_data;
    assign bus.pre_address = r_main.pre_address;
    assign bus.instruction = r_main.instruction;
    assign o_stall_cycles  = r_stall;

endmodule
